// File: rtl/cdb_broadcaster.sv
// Common data bus producer: per-FU result FIFOs drained one entry per cycle
// by a round-robin arbiter into a registered CDB broadcast.
module cdb_broadcaster #(
  parameter int N_FU  = 4,
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    squash,
  input  logic [N_FU-1:0]         fu_valid,
  input  logic [N_FU*TAG_W-1:0]   fu_tag,
  input  logic [N_FU*XLEN-1:0]    fu_value,
  output logic [N_FU-1:0]         fu_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [XLEN-1:0]         cdb_value
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (N_FU > 1) ? $clog2(N_FU) : 1;
  localparam int EW = TAG_W + XLEN;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [EW-1:0]    mem_q [N_FU][DEPTH];
  logic [CW-1:0]    cnt_q [N_FU];
  logic [CW-1:0]    cnt_d [N_FU];
  logic [PW-1:0]    wr_q  [N_FU];
  logic [PW-1:0]    wr_d  [N_FU];
  logic [PW-1:0]    rd_q  [N_FU];
  logic [PW-1:0]    rd_d  [N_FU];
  logic [RW-1:0]    rr_q, rr_d;
  logic [RW-1:0]    win_s;
  logic             grant_s;
  logic [N_FU-1:0]  push_s, pop_s;
  logic [EW-1:0]    head_s;
  logic             cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [XLEN-1:0]  cdb_value_q, cdb_value_d;

  function automatic logic [RW-1:0] rr_add(input logic [RW-1:0] base, input int off);
    return RW'((int'(base) + off) % N_FU);
  endfunction

  // Ready and push qualification depend only on registered occupancy.
  always_comb begin
    for (int i = 0; i < N_FU; i++) begin
      fu_ready[i] = (cnt_q[i] != FULL_CNT);
      push_s[i]   = fu_valid[i] && (cnt_q[i] != FULL_CNT);
    end
  end

  // Round-robin scan starting at rr_q; first non-empty FIFO wins.
  always_comb begin
    grant_s = 1'b0;
    win_s   = '0;
    for (int k = 0; k < N_FU; k++) begin
      win_s   = (!grant_s && (cnt_q[rr_add(rr_q, k)] != '0)) ? rr_add(rr_q, k) : win_s;
      grant_s = grant_s || (cnt_q[rr_add(rr_q, k)] != '0);
    end
    head_s = mem_q[win_s][rd_q[win_s]];
    for (int i = 0; i < N_FU; i++) begin
      pop_s[i] = grant_s && (win_s == RW'(i));
    end
  end

  // FIFO bookkeeping; squash clears occupancy and overrides push/pop.
  always_comb begin
    for (int i = 0; i < N_FU; i++) begin
      cnt_d[i] = cnt_q[i];
      wr_d[i]  = wr_q[i];
      rd_d[i]  = rd_q[i];
      if (squash) begin
        cnt_d[i] = '0;
        wr_d[i]  = '0;
        rd_d[i]  = '0;
      end else begin
        wr_d[i] = push_s[i] ? (wr_q[i] + PTR_ONE) : wr_q[i];
        rd_d[i] = pop_s[i]  ? (rd_q[i] + PTR_ONE) : rd_q[i];
        case ({push_s[i], pop_s[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
          2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
  end

  // Next broadcast and arbitration pointer.
  always_comb begin
    if (grant_s && !squash) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = head_s[EW-1:XLEN];
      cdb_value_d = head_s[XLEN-1:0];
      rr_d        = rr_add(win_s, 1);
    end else begin
      cdb_valid_d = 1'b0;
      cdb_tag_d   = '0;
      cdb_value_d = '0;
      rr_d        = rr_q;
    end
  end

  // Control state and output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_FU; i++) begin
        cnt_q[i] <= '0;
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
      end
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        cnt_q[i] <= cnt_d[i];
        wr_q[i]  <= wr_d[i];
        rd_q[i]  <= rd_d[i];
      end
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  // Result storage; pushes in a squash cycle are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_FU; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        if (push_s[i] && !squash) begin
          mem_q[i][wr_q[i]] <= {fu_tag[i*TAG_W +: TAG_W], fu_value[i*XLEN +: XLEN]};
        end else begin
          mem_q[i][wr_q[i]] <= mem_q[i][wr_q[i]];
        end
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_value_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: vector table plus hand-written
// backpressure and mid-stream reset sequences.
module tb_cdb_broadcaster;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         squash = 1'b0;
  logic [3:0]   fu_valid = 4'b0;
  logic [19:0]  fu_tag = 20'h0;
  logic [127:0] fu_value = 128'h0;
  logic [3:0]   fu_ready;
  logic         cdb_valid;
  logic [4:0]   cdb_tag;
  logic [31:0]  cdb_value;

  int n_total = 0;
  int n_pass  = 0;

  cdb_broadcaster dut (
    .clock    (clock),
    .reset    (reset),
    .squash   (squash),
    .fu_valid (fu_valid),
    .fu_tag   (fu_tag),
    .fu_value (fu_value),
    .fu_ready (fu_ready),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_value(cdb_value)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         rst;
    logic         sq;
    logic [3:0]   v;
    logic [19:0]  tg;
    logic [127:0] vl;
    logic         ev;
    logic [4:0]   et;
    logic [31:0]  evl;
    logic [3:0]   erdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic sq, logic [3:0] v, logic [19:0] tg, logic [127:0] vl,
                              logic ev, logic [4:0] et, logic [31:0] evl, logic [3:0] erdy);
    vec_t r;
    r.rst = rst; r.sq = sq; r.v = v; r.tg = tg; r.vl = vl;
    r.ev = ev; r.et = et; r.evl = evl; r.erdy = erdy;
    return r;
  endfunction

  function automatic vec_t idle(logic ev, logic [4:0] et, logic [31:0] evl, logic [3:0] erdy);
    return mk(1'b0, 1'b0, 4'b0, 20'h0, 128'h0, ev, et, evl, erdy);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic outs_idle(input string nm);
    chk(nm, {22'h0, cdb_valid, cdb_tag, cdb_value, fu_ready}, {22'h0, 1'b0, 5'h0, 32'h0, 4'hF});
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  task automatic apply_row(input int n, input vec_t r);
    @(negedge clock);
    if (r.rst) begin
      #2 reset = 1'b1;
      #1 reset = 1'b0;
    end
    squash = r.sq; fu_valid = r.v; fu_tag = r.tg; fu_value = r.vl;
    #1;
    chk($sformatf("row%0d", n), {22'h0, cdb_valid, cdb_tag, cdb_value, fu_ready},
        {22'h0, r.ev, r.et, r.evl, r.erdy});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent0, sent1, bcnt, first, last;
    logic saw_low;
    logic [4:0] t0, t1, et;
    logic [31:0] ev;

    // Single result: broadcast two cycles after the handshake, one cycle long.
    tbl.push_back(mk(1'b1, 1'b0, 4'b0001, 20'h00005, {96'h0, 32'hDEAD_BEEF}, 1'b0, 5'h0, 32'h0, 4'hF));
    tbl.push_back(idle(1'b0, 5'h0, 32'h0, 4'hF));
    tbl.push_back(idle(1'b1, 5'd5, 32'hDEAD_BEEF, 4'hF));
    tbl.push_back(idle(1'b0, 5'h0, 32'h0, 4'hF));
    // Four-way collision from rr_ptr 0, then a tag-0 result proves rr returned to 0.
    tbl.push_back(mk(1'b1, 1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},
                     {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001}, 1'b0, 5'h0, 32'h0, 4'hF));
    tbl.push_back(idle(1'b0, 5'h0, 32'h0, 4'hF));
    tbl.push_back(idle(1'b1, 5'd1, 32'h1111_0001, 4'hF));
    tbl.push_back(idle(1'b1, 5'd2, 32'h2222_0002, 4'hF));
    tbl.push_back(idle(1'b1, 5'd3, 32'h3333_0003, 4'hF));
    tbl.push_back(idle(1'b1, 5'd4, 32'h4444_0004, 4'hF));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0011, {5'd0, 5'd0, 5'd10, 5'd0},
                     {64'h0, 32'hAAAA_000A, 32'h9999_0000}, 1'b0, 5'h0, 32'h0, 4'hF));
    tbl.push_back(idle(1'b0, 5'h0, 32'h0, 4'hF));
    tbl.push_back(idle(1'b1, 5'd0, 32'h9999_0000, 4'hF));
    tbl.push_back(idle(1'b1, 5'd10, 32'hAAAA_000A, 4'hF));
    tbl.push_back(idle(1'b0, 5'h0, 32'h0, 4'hF));
    // Squash with three entries pending in FUs 1/2 and a dropped FU3 push.
    tbl.push_back(mk(1'b1, 1'b0, 4'b0110, {5'd0, 5'd12, 5'd11, 5'd0},
                     {32'h0, 32'h2000_000C, 32'h1000_000B, 32'h0}, 1'b0, 5'h0, 32'h0, 4'hF));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0110, {5'd0, 5'd14, 5'd13, 5'd0},
                     {32'h0, 32'h2000_000E, 32'h1000_000D, 32'h0}, 1'b0, 5'h0, 32'h0, 4'hF));
    tbl.push_back(mk(1'b0, 1'b1, 4'b1000, {5'd7, 15'h0}, {32'h3000_0007, 96'h0},
                     1'b1, 5'd11, 32'h1000_000B, 4'b1011));
    tbl.push_back(idle(1'b0, 5'h0, 32'h0, 4'hF));
    tbl.push_back(idle(1'b0, 5'h0, 32'h0, 4'hF));
    tbl.push_back(idle(1'b0, 5'h0, 32'h0, 4'hF));
    // rr_ptr held at 2 through the squash, so FU2 beats FU1.
    tbl.push_back(mk(1'b0, 1'b0, 4'b0110, {5'd0, 5'd22, 5'd21, 5'd0},
                     {32'h0, 32'h2000_0016, 32'h1000_0015, 32'h0}, 1'b0, 5'h0, 32'h0, 4'hF));
    tbl.push_back(idle(1'b0, 5'h0, 32'h0, 4'hF));
    tbl.push_back(idle(1'b1, 5'd22, 32'h2000_0016, 4'hF));
    tbl.push_back(idle(1'b1, 5'd21, 32'h1000_0015, 4'hF));
    tbl.push_back(idle(1'b0, 5'h0, 32'h0, 4'hF));

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1 outs_idle("reset_async");
    #3 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1 outs_idle($sformatf("reset_idle%0d", c));
    end

    for (int n = 0; n < tbl.size(); n++) apply_row(n, tbl[n]);

    // Backpressure: FU0/FU1 stream six results each into DEPTH-2 FIFOs.
    squash = 1'b0; fu_valid = 4'b0;
    pulse_reset();
    sent0 = 0; sent1 = 0; bcnt = 0; first = -1; last = -1; saw_low = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clock);
      t0 = 5'h10 + 5'(sent0);
      t1 = 5'h18 + 5'(sent1);
      fu_valid = {2'b00, (sent1 < 6), (sent0 < 6)};
      fu_tag   = {10'h0, t1, t0};
      fu_value = {64'h0, 32'hB100_0000 | {27'h0, t1}, 32'hB000_0000 | {27'h0, t0}};
      #1;
      if (!fu_ready[1]) saw_low = 1'b1;
      if (cdb_valid) begin
        if (bcnt < 12) begin
          et = ((bcnt % 2) == 0) ? 5'h10 + 5'(bcnt / 2) : 5'h18 + 5'(bcnt / 2);
          ev = ((bcnt % 2) == 0) ? 32'hB000_0000 | {27'h0, et} : 32'hB100_0000 | {27'h0, et};
          chk($sformatf("bp_bcast%0d", bcnt), {27'h0, cdb_tag, cdb_value}, {27'h0, et, ev});
        end else begin
          chk("bp_extra", {63'h0, cdb_valid}, 64'h0);
        end
        if (first < 0) first = cyc;
        last = cyc;
        bcnt++;
      end
      if (fu_valid[0] && fu_ready[0]) sent0++;
      if (fu_valid[1] && fu_ready[1]) sent1++;
    end
    fu_valid = 4'b0;
    chk("bp_count", 64'(bcnt), 64'd12);
    chk("bp_ready1_low", {63'h0, saw_low}, 64'h1);
    chk("bp_first", 64'(first), 64'd2);
    chk("bp_last", 64'(last), 64'd13);

    // Reset mid-stream with four entries queued and a broadcast on the bus.
    pulse_reset();
    @(negedge clock);
    fu_valid = 4'b1111; fu_tag = {5'd4, 5'd3, 5'd2, 5'd1};
    fu_value = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
    @(negedge clock);
    fu_valid = 4'b0001; fu_tag = {15'h0, 5'd5}; fu_value = {96'h0, 32'h0000_0055};
    @(negedge clock);
    fu_valid = 4'b0;
    #1 chk("mid_pre", {26'h0, cdb_valid, cdb_tag, cdb_value}, {26'h0, 1'b1, 5'd1, 32'h0000_0011});
    #1 reset = 1'b1;
    #1 outs_idle("mid_async");
    #1 reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      #1 outs_idle($sformatf("mid_after%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
